// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock.
// A start/busy/done handshake sequences each operation; Diff and Borrow
// update only on the completion edge and hold until the next one.
// Optional feature: define SERIAL_SUB_OVF_EN to add the Overflow output
// (signed two's-complement overflow of the subtraction).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-bit full subtract: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CW-1:0]    count_r;
  logic             last_bit_s;
  logic [1:0]       bit_res_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
`endif

  // Bit-slice subtract on the current LSBs and the stored borrow.
  always_comb begin
    bit_res_s = sub_bit(a_sh_r[0], b_sh_r[0], borrow_r);
  end

  // Next-state decode; the final bit is flagged when the counter hits WIDTH-1.
  always_comb begin
    state_next_s = state_r;
    last_bit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (count_r == LAST_CNT) begin
          last_bit_s   = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake outputs as registered decodes of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next_s == SHIFT);
      done <= (state_next_s == DONE);
    end
  end

  // Operand capture, serial shifting and publication of the final result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      count_r  <= {CW{1'b0}};
      Diff     <= {WIDTH{1'b0}};
      Borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      Overflow <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= A;
            b_sh_r   <= B;
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            count_r  <= {CW{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r  <= A[WIDTH-1];
            b_msb_r  <= B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_r    <= {bit_res_s[0], res_r[WIDTH-1:1]};
          borrow_r <= bit_res_s[1];
          count_r  <= count_r + CW'(1);
          if (last_bit_s) begin
            Diff   <= {bit_res_s[0], res_r[WIDTH-1:1]};
            Borrow <= bit_res_s[1];
`ifdef SERIAL_SUB_OVF_EN
            // The bit produced on this edge is the result MSB.
            Overflow <= (a_msb_r != b_msb_r) && (bit_res_s[0] != a_msb_r);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
